letc_core_limp_arbiter: RTL and testbench

LETC_CORE_LIMP_ARBITER -- requirements
Module: letc_core_limp_arbiter

---
 rtl/letc_core_limp_arbiter.sv | 138 +++++++++++++
 tb/tb_letc_core_limp_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/letc_core_limp_arbiter.sv
// Round-robin arbiter funnelling the L1I/L1D/MMU LIMP requesters onto the single
// downstream LIMP port; the winning request is latched so requesters cannot disturb it.
//
//   state    | meaning
//   ST_IDLE  | no transaction; pick the next requester round-robin from last grant
//   ST_GRANT | captured request presented downstream, waiting for i_mem_ready
module letc_core_limp_arbiter #(
  parameter  int N_REQ  = 3,
  parameter  int ADDR_W = 34,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ-1:0]          i_req_wen_nren,
  input  logic [2*N_REQ-1:0]        i_req_size,
  input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_req_wdata,
  output logic [DATA_W-1:0]         o_req_rdata,
  output logic                      o_req_illegal,
  output logic                      o_mem_valid,
  output logic                      o_mem_wen_nren,
  output logic [1:0]                o_mem_size,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic                      i_mem_ready,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  input  logic                      i_mem_illegal,
  output logic [IDX_W-1:0]          o_grant_idx,
  output logic                      o_busy,
  output logic                      o_protocol_err
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic                wen_q, wen_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                perr_q, perr_d;

  logic [1:0]          size_arr  [N_REQ];
  logic [ADDR_W-1:0]   addr_arr  [N_REQ];
  logic [DATA_W-1:0]   wdata_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign size_arr[g]  = i_req_size[g*2 +: 2];
    assign addr_arr[g]  = i_req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = i_req_wdata[g*DATA_W +: DATA_W];
  end

  // Search starts one past the last grant so every requester gets a turn.
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_q;
    cand       = grant_q;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(grant_q) + k) % N_REQ);
      if (!pick_found && i_req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    wen_d         = wen_q;
    size_d        = size_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    perr_d        = perr_q;
    o_req_ready   = '0;
    o_req_rdata   = '0;
    o_req_illegal = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          grant_d = pick_idx;
          wen_d   = i_req_wen_nren[pick_idx];
          size_d  = size_arr[pick_idx];
          addr_d  = addr_arr[pick_idx];
          wdata_d = wdata_arr[pick_idx];
        end
      end
      ST_GRANT: begin
        if (!i_req_valid[grant_q]) perr_d = 1'b1;
        if (i_mem_ready) begin
          o_req_ready[grant_q] = 1'b1;
          o_req_rdata          = i_mem_rdata;
          o_req_illegal        = i_mem_illegal;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= IDX_W'(N_REQ - 1);
      wen_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      perr_q  <= perr_d;
    end
  end

  assign o_busy         = (state_q == ST_GRANT);
  assign o_mem_valid    = o_busy;
  assign o_mem_wen_nren = wen_q;
  assign o_mem_size     = size_q;
  assign o_mem_addr     = addr_q;
  assign o_mem_wdata    = wdata_q;
  assign o_grant_idx    = grant_q;
  assign o_protocol_err = perr_q;

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// Scoreboard bench for letc_core_limp_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level round-robin model in the negedge monitor.
module tb_letc_core_limp_arbiter;
  localparam int N  = 3;
  localparam int AW = 34;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_wen, req_ready;
  logic [2*N-1:0]  req_size;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   req_rdata;
  logic            req_illegal;
  logic            mem_valid, mem_wen;
  logic [1:0]      mem_size;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_illegal = 1'b0;
  logic [IW-1:0]   grant_idx;
  logic            busy, perr;

  letc_core_limp_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen_nren(req_wen),
    .i_req_size(req_size), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_rdata(req_rdata), .o_req_illegal(req_illegal),
    .o_mem_valid(mem_valid), .o_mem_wen_nren(mem_wen), .o_mem_size(mem_size),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .i_mem_illegal(mem_illegal),
    .o_grant_idx(grant_idx), .o_busy(busy), .o_protocol_err(perr)
  );

  typedef struct packed {
    logic          wen;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } rec_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          ill;
  } resp_t;

  rec_t  req_q [N][$];
  resp_t resp_q[$];

  // Stimulus controls, written only by the stimulus process.
  int            dmin = 0, dmax = 0;
  bit            auto_en = 1'b0;
  bit            force_en = 1'b0;
  logic [DW-1:0] force_data = '0;
  logic          force_ill = 1'b0;
  int            tmo_pending = 0;
  bit            stim_done = 1'b0;

  // Monitor-owned state.
  logic [N-1:0]  ready_seen = '0;
  int            errors = 0, checks = 0;

  // Downstream memory model: random latency, random response, junk ready pulses in IDLE.
  int cnt = 0, target = 0;
  bit in_txn = 1'b0;
  always @(posedge clk) begin
    #1;
    mem_ready   = 1'b0;
    mem_rdata   = $urandom;
    mem_illegal = 1'($urandom_range(1, 0));
    if (!rst_n) begin
      in_txn = 1'b0;
    end else if (mem_valid) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        cnt    = 0;
        target = int'($urandom_range(dmax, dmin));
      end
      if (cnt == target) begin
        mem_ready = 1'b1;
        in_txn    = 1'b0;
        if (force_en) begin
          mem_rdata   = force_data;
          mem_illegal = force_ill;
        end
        resp_q.push_back('{rdata: mem_rdata, ill: mem_illegal});
      end else begin
        cnt++;
      end
    end else begin
      in_txn    = 1'b0;
      mem_ready = ($urandom_range(3, 0) == 0);
    end
  end

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return last;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int           last_m = N - 1;
  bit           busy_m = 1'b0, prev_done = 1'b0, perr_m = 1'b0, done;
  logic [N-1:0] prev_valid = '0;
  logic [N-1:0] exp_rdy;
  rec_t         cur = '0;
  resp_t        rsp;
  int           tmo_seen = 0, cyc = 0;

  always @(negedge clk) begin
    cyc++;
    ready_seen = req_ready;
    if (tmo_pending != tmo_seen) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: got %0d expired waits expected 0", tmo_pending);
      tmo_seen = tmo_pending;
    end
    if (!rst_n) begin
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_mem_valid", 64'(mem_valid), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_rdata", 64'(req_rdata), 64'(0));
      chk("rst_illegal", 64'(req_illegal), 64'(0));
      chk("rst_perr", 64'(perr), 64'(0));
      chk("rst_grant_idx", 64'(grant_idx), 64'(N - 1));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      last_m = N - 1; busy_m = 1'b0; prev_done = 1'b0; perr_m = 1'b0;
      prev_valid = '0; cur = '0;
      resp_q.delete();
    end else begin
      if (busy_m) begin
        busy_m = !prev_done;
      end else if (prev_valid != '0) begin
        busy_m = 1'b1;
        last_m = rr_pick(last_m, prev_valid);
        chk("grant_has_request", 64'(req_q[last_m].size() != 0), 64'(1));
        cur = (req_q[last_m].size() != 0) ? req_q[last_m].pop_front() : '0;
      end
      chk("busy", 64'(busy), 64'(busy_m));
      chk("mem_valid", 64'(mem_valid), 64'(busy_m));
      chk("grant_idx", 64'(grant_idx), 64'(last_m));
      if (busy_m) begin
        chk("mem_wen", 64'(mem_wen), 64'(cur.wen));
        chk("mem_size", 64'(mem_size), 64'(cur.size));
        chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
      end
      done = busy_m && mem_ready;
      exp_rdy = '0;
      if (done) begin
        exp_rdy[last_m] = 1'b1;
        chk("resp_pending", 64'(resp_q.size() != 0), 64'(1));
        rsp = (resp_q.size() != 0) ? resp_q.pop_front() : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("req_rdata", 64'(req_rdata), 64'(rsp.rdata));
        chk("req_illegal", 64'(req_illegal), 64'(rsp.ill));
      end else begin
        chk("req_ready_idle", 64'(req_ready), 64'(exp_rdy));
        chk("req_rdata_idle", 64'(req_rdata), 64'(0));
        chk("req_illegal_idle", 64'(req_illegal), 64'(0));
      end
      chk("protocol_err", 64'(perr), 64'(perr_m));
      if (busy_m && !req_valid[last_m]) perr_m = 1'b1;
      prev_done  = done;
      prev_valid = req_valid;
    end
    if (stim_done || cyc > 50000) begin
      if (!stim_done) begin
        errors++;
        $display("FAIL watchdog: got %0d cycles expected stimulus to finish", cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic start_req(input int r, input logic wen, input logic [1:0] sz,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    rec_t rc;
    req_valid[r]             = 1'b1;
    req_wen[r]               = wen;
    req_size[r*2 +: 2]       = sz;
    req_addr[r*AW +: AW]     = a;
    req_wdata[r*DW +: DW]    = d;
    rc.wen = wen; rc.size = sz; rc.addr = a; rc.wdata = d;
    req_q[r].push_back(rc);
  endtask

  task automatic rand_req(input int r);
    logic [63:0] a64;
    a64 = {$urandom, $urandom};
    start_req(r, 1'($urandom), 2'($urandom_range(2, 0)), a64[AW-1:0], $urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) if (ready_seen[r]) req_valid[r] = 1'b0;
    if (auto_en)
      for (int r = 0; r < N; r++)
        if (!req_valid[r] && !ready_seen[r] && $urandom_range(2, 0) == 0) rand_req(r);
  endtask

  task automatic wait_quiet(input int max);
    int i;
    i = 0;
    while ((req_valid != '0 || busy) && i < max) begin
      tick();
      i++;
    end
    if (i >= max) tmo_pending++;
  endtask

  initial begin
    bit r0_again;
    req_valid = '0; req_wen = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single read from requester 1
    force_en = 1'b1; force_data = 32'hDEAD_BEEF; force_ill = 1'b0; dmin = 0; dmax = 0;
    start_req(1, 1'b0, 2'd2, 34'h0_8000_0000, 32'h0);
    wait_quiet(20);
    force_en = 1'b0;

    // All three requesting; requester 0 re-requests after being served
    dmin = 0; dmax = 2;
    rand_req(0); rand_req(1); rand_req(2);
    r0_again = 1'b0;
    for (int i = 0; i < 60 && (req_valid != '0 || busy); i++) begin
      tick();
      if (!r0_again && !req_valid[0]) begin
        r0_again = 1'b1;
        rand_req(0);
      end
    end
    wait_quiet(30);

    // Requester 2 write; its inputs change while granted
    dmin = 3; dmax = 3;
    start_req(2, 1'b1, 2'd2, 34'h1_2340_0000, 32'h1234_5678);
    tick();
    req_addr[2*AW +: AW]  = 34'h3_0000_0004;
    req_wdata[2*DW +: DW] = 32'hCAFE_F00D;
    wait_quiet(20);

    // Granted requester drops valid early
    start_req(0, 1'b0, 2'd0, 34'h0_0000_1001, 32'h0);
    tick();
    tick();
    req_valid[0] = 1'b0;
    wait_quiet(20);

    // Access fault on one transaction
    dmin = 1; dmax = 1;
    force_en = 1'b1; force_ill = 1'b1; force_data = 32'h0BAD_0BAD;
    start_req(1, 1'b0, 2'd1, 34'h2_0000_0002, 32'h0);
    wait_quiet(20);
    force_en = 1'b0;

    // Random traffic
    dmin = 0; dmax = 3; auto_en = 1'b1;
    repeat (1500) tick();
    auto_en = 1'b0;
    wait_quiet(60);

    // Reset mid-GRANT, then requesters 0 and 1 together
    dmin = 6; dmax = 6;
    rand_req(1);
    tick();
    tick();
    rst_n = 1'b0;
    req_valid = '0;
    for (int r = 0; r < N; r++) req_q[r].delete();
    tick();
    tick();
    rst_n = 1'b1;
    dmin = 0; dmax = 2;
    rand_req(1); rand_req(0);
    wait_quiet(30);

    auto_en = 1'b1;
    repeat (400) tick();
    auto_en = 1'b0;
    wait_quiet(60);
    tick();
    stim_done = 1'b1;
  end

endmodule
